// File: rtl/ex_div_unit_if.sv
// Handshake/bus bundle between the EX stage and the multi-cycle divider.
// master = EX-stage requester, slave = divider engine.
interface ex_div_unit_if #(
   parameter int DATA_W  = 32,
   parameter int STALL_W = 6
);
   logic [STALL_W-1:0] stall;
   logic               div_start;
   logic               div_signed;
   logic               div_cancel;
   logic [DATA_W-1:0]  op_a;
   logic [DATA_W-1:0]  op_b;
   logic               stallreq_from_ex;
   logic               div_ready;
   logic [DATA_W-1:0]  lo_o;
   logic [DATA_W-1:0]  hi_o;

   modport master (
      output stall, div_start, div_signed, div_cancel, op_a, op_b,
      input  stallreq_from_ex, div_ready, lo_o, hi_o
   );

   modport slave (
      input  stall, div_start, div_signed, div_cancel, op_a, op_b,
      output stallreq_from_ex, div_ready, lo_o, hi_o
   );
endinterface

// File: rtl/ex_div_unit.sv
// Restoring DIV/DIVU engine for the EX stage: one quotient bit per cycle,
// stalls the pipeline while busy and holds its result while EX is frozen.
module ex_div_unit #(
   parameter int DATA_W       = 32,
   parameter int STALL_W      = 6,
   parameter int EX_STALL_BIT = 3
) (
   input  logic           clk,
   input  logic           rst,
   ex_div_unit_if.slave   div_if
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [5:0] LAST_CNT = 6'(DATA_W - 1);

   state_t              state_q, state_d;
   logic [5:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   rem_q, rem_d;
   logic [DATA_W-1:0]   dvd_q, dvd_d;
   logic [DATA_W-1:0]   dvs_q, dvs_d;
   logic                neg_quo_q, neg_quo_d;
   logic                neg_rem_q, neg_rem_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic                ready_q, ready_d;

   logic [DATA_W:0]     rem_shift;
   logic [DATA_W:0]     trial;
   logic                borrow;
   logic [DATA_W-1:0]   step_rem;
   logic [DATA_W-1:0]   step_quo;
   logic [DATA_W-1:0]   abs_a;
   logic [DATA_W-1:0]   abs_b;
   logic                unused_stall;

   // Only the EX-stage bit matters; the rest of the stall vector is ignored.
   assign unused_stall = ^div_if.stall;

   assign abs_a = (div_if.div_signed && div_if.op_a[DATA_W-1]) ? -div_if.op_a : div_if.op_a;
   assign abs_b = (div_if.div_signed && div_if.op_b[DATA_W-1]) ? -div_if.op_b : div_if.op_b;

   // Remainder can reach 2*divisor after the shift, so trial-subtract in DATA_W+1
   // bits; the top bit of the difference is the borrow.
   assign rem_shift = {rem_q, dvd_q[DATA_W-1]};
   assign trial     = rem_shift - {1'b0, dvs_q};
   assign borrow    = trial[DATA_W];
   assign step_rem  = borrow ? rem_shift[DATA_W-1:0] : trial[DATA_W-1:0];
   assign step_quo  = {dvd_q[DATA_W-2:0], ~borrow};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      ready_d   = ready_q;
      if (div_if.div_cancel) begin
         state_d = IDLE;
         ready_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_d = 1'b0;
               if (div_if.div_start) begin
                  if (div_if.op_b == '0) begin
                     // Divide by zero yields a fixed result instead of trapping.
                     lo_d    = '1;
                     hi_d    = div_if.op_a;
                     ready_d = 1'b1;
                     state_d = DONE;
                  end else begin
                     dvd_d     = abs_a;
                     dvs_d     = abs_b;
                     neg_quo_d = div_if.div_signed & (div_if.op_a[DATA_W-1] ^ div_if.op_b[DATA_W-1]);
                     neg_rem_d = div_if.div_signed & div_if.op_a[DATA_W-1];
                     rem_d     = '0;
                     cnt_d     = '0;
                     state_d   = BUSY;
                  end
               end
            end
            BUSY: begin
               rem_d = step_rem;
               dvd_d = step_quo;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == LAST_CNT) begin
                  lo_d    = neg_quo_q ? -step_quo : step_quo;
                  hi_d    = neg_rem_q ? -step_rem : step_rem;
                  ready_d = 1'b1;
                  cnt_d   = '0;
                  state_d = DONE;
               end
            end
            DONE: begin
               if (!div_if.stall[EX_STALL_BIT]) begin
                  ready_d = 1'b0;
                  state_d = IDLE;
               end
            end
            default: begin
               ready_d = 1'b0;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         lo_q      <= '0;
         hi_q      <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         ready_q   <= ready_d;
      end
   end

   assign div_if.stallreq_from_ex = div_if.div_start & ~div_if.div_cancel & (state_q != DONE);
   assign div_if.div_ready        = ready_q;
   assign div_if.lo_o             = lo_q;
   assign div_if.hi_o             = hi_q;
endmodule
